// File: rtl/cpu_if_pkg.sv
// Shared types for the instruction-fetch stage.
// Fetch FSM states, queue entry layout and fetch constants.
package cpu_if_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
        logic        tag;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_fetch_queue.sv
// Small FIFO of fetched instructions between imem and decode.
// Flush beats push; push while full is taken only with a pop.
module if_fetch_queue
    import cpu_if_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [31:0]  o_next_pc4,
    output logic         o_next_vld,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(QDEPTH);

    fetch_entry_t  r_mem [QDEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_rd_nx;

    assign o_empty    = (r_cnt == '0);
    assign o_full     = (r_cnt == (AW+1)'(QDEPTH));
    assign w_pop      = i_pop && !o_empty;
    assign w_push     = i_push && (!o_full || w_pop);
    assign w_rd_nx    = r_rd + AW'(1);
    assign o_head     = r_mem[r_rd];
    assign o_next_pc4 = r_mem[w_rd_nx].pc_plus_4;
    assign o_next_vld = (r_cnt > (AW+1)'(1));

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= w_rd_nx;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem fetch, 2-deep queue.
// Optional IF_PERF_CNT_EN adds saturating perf_fetch/stall/flush counters.
module if_stage
    import cpu_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INTR_VEC = 32'h0000_0100,
    parameter int          QDEPTH   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_branch_sel,
    input  logic [31:0] i_branch_pc,
    input  logic        i_stall,
    input  logic        i_intr_req,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_out_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus_4,
    output logic        o_interrupt,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_stall,
    output logic [31:0] o_perf_flush,
`endif
    output logic [31:0] o_epc
);

    fetch_state_e r_state;
    fetch_state_e w_state_nx;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_pc;
    logic         r_fetch_tag;
    logic         r_intr_q;
    logic         r_intr_pend;
    logic         r_intr_acc;
    logic [31:0]  r_epc;

    fetch_entry_t w_head;
    fetch_entry_t w_push_data;
    logic [31:0]  w_next_pc4;
    logic         w_next_vld;
    logic         w_full;
    logic         w_empty;
    logic         w_accept;
    logic         w_flush;
    logic         w_pop;
    logic         w_push;
    logic         w_gnt;
    logic         w_can_req;
    logic [31:0]  w_branch_pc;
    logic [31:0]  w_ret_pc;

    assign w_branch_pc = i_branch_pc & 32'hFFFF_FFFC;
    assign w_accept    = r_intr_pend && !r_intr_acc && !i_branch_sel;
    assign w_flush     = i_branch_sel || w_accept;
    assign w_pop       = o_out_valid && !i_stall && !i_branch_sel;
    assign w_can_req   = !w_full || w_pop;
    assign w_gnt       = o_imem_req && i_imem_gnt;
    assign w_push      = (r_state == WAIT) && i_imem_rvalid && !w_flush;
    assign w_push_data = '{instr:     i_imem_rdata,
                           pc_plus_4: r_fetch_pc + PC_STEP,
                           tag:       r_fetch_tag};

    assign o_imem_addr = r_pc;
    assign o_out_valid = !w_empty;
    assign o_instr     = o_out_valid ? w_head.instr : NOP_INSTR;
    assign o_pc_plus_4 = o_out_valid ? w_head.pc_plus_4 : 32'h0;
    assign o_interrupt = o_out_valid && w_head.tag;
    assign o_epc       = r_epc;

    if_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .i_data     (w_push_data),
        .o_head     (w_head),
        .o_next_pc4 (w_next_pc4),
        .o_next_vld (w_next_vld),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Return address: oldest instruction not yet handed to decode.
    always_comb begin
        w_ret_pc = r_pc;
        if (!w_empty && !w_pop) begin
            w_ret_pc = w_head.pc_plus_4 - PC_STEP;
        end else if (w_next_vld) begin
            w_ret_pc = w_next_pc4 - PC_STEP;
        end else if (r_state == WAIT) begin
            w_ret_pc = r_fetch_pc;
        end
    end

    // Fetch FSM next state and request; flushed grants get discarded.
    always_comb begin
        w_state_nx = r_state;
        o_imem_req = 1'b0;
        unique case (r_state)
            REQ: begin
                o_imem_req = w_can_req && !i_rst;
                if (w_gnt) w_state_nx = w_flush ? DISCARD : WAIT;
            end
            WAIT: begin
                if (i_imem_rvalid) w_state_nx = REQ;
                else if (w_flush)  w_state_nx = DISCARD;
            end
            DISCARD: begin
                if (i_imem_rvalid) w_state_nx = REQ;
            end
            default: w_state_nx = REQ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= REQ;
        else       r_state <= w_state_nx;
    end

    // PC, in-flight fetch info and interrupt bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_fetch_pc  <= 32'h0;
            r_fetch_tag <= 1'b0;
            r_intr_q    <= 1'b0;
            r_intr_pend <= 1'b0;
            r_intr_acc  <= 1'b0;
            r_epc       <= 32'h0;
        end else begin
            r_intr_q <= i_intr_req;
            if (i_branch_sel)  r_pc <= w_branch_pc;
            else if (w_accept) r_pc <= INTR_VEC;
            else if (w_gnt)    r_pc <= r_pc + PC_STEP;
            if (w_gnt) begin
                r_fetch_pc  <= r_pc;
                r_fetch_tag <= r_intr_acc;
            end
            if (w_accept) begin
                r_epc      <= w_ret_pc;
                r_intr_acc <= 1'b1;
            end else if (i_branch_sel) begin
                r_intr_acc <= 1'b0;
            end
            if (i_intr_req && !r_intr_q && !r_intr_pend) begin
                r_intr_pend <= 1'b1;
            end
            if (w_push && r_fetch_tag) begin
                r_intr_pend <= 1'b0;
                r_intr_acc  <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating event counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (w_pop && r_perf_fetch != '1)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (o_out_valid && i_stall && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_flush && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign o_perf_fetch = r_perf_fetch;
    assign o_perf_stall = r_perf_stall;
    assign o_perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed phases push expected
// outputs; a negedge monitor pops and compares on each handoff.
module tb_if_stage;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
        logic        t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_sel = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic        stall = 1'b0;
    logic        intr_req = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
    logic        interrupt;
    logic [31:0] epc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int lat     = 1;
    exp_t exp_q[$];
    int   pop_cyc[$];

    logic        m_busy = 1'b0;
    logic [31:0] m_addr = 32'h0;
    int          m_cnt  = 0;

    if_stage dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_branch_sel  (branch_sel),
        .i_branch_pc   (branch_pc),
        .i_stall       (stall),
        .i_intr_req    (intr_req),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_out_valid   (out_valid),
        .o_instr       (instr),
        .o_pc_plus_4   (pc_plus_4),
        .o_interrupt   (interrupt),
`ifdef IF_PERF_CNT_EN
        .o_perf_fetch  (perf_fetch),
        .o_perf_stall  (perf_stall),
        .o_perf_flush  (perf_flush),
`endif
        .o_epc         (epc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returning its address as data after lat cycles.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= m_addr;
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (imem_req && imem_gnt) begin
            if (lat == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= imem_addr;
            end else begin
                m_busy <= 1'b1;
                m_addr <= imem_addr;
                m_cnt  <= lat - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    task automatic expect_out(input logic [31:0] i, input logic [31:0] p,
                              input logic t);
        exp_t e;
        e.i = i;
        e.p = p;
        e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ends 1 time unit after the first edge with rst released.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        stall      = 1'b0;
        branch_sel = 1'b0;
        intr_req   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pop_cyc.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: compare every handoff to decode against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && !stall && !branch_sel) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out.instr", instr, e.i);
                chk("out.pc_plus_4", pc_plus_4, e.p);
                chk("out.interrupt", {31'h0, interrupt}, {31'h0, e.t});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        chk("rst.imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.pc_plus_4", pc_plus_4, 32'h0);
        chk("rst.interrupt", {31'h0, interrupt}, 32'h0);
        chk("rst.epc", epc, 32'h0);

        // Free run from RESET_PC.
        lat = 1;
        do_reset();
        expect_out(32'h0, 32'h4, 1'b0);
        expect_out(32'h4, 32'h8, 1'b0);
        expect_out(32'h8, 32'hC, 1'b0);
        expect_out(32'hC, 32'h10, 1'b0);
        tick(1);
        #1;
        chk("run.valid_after_gnt", {31'h0, out_valid}, 32'h0);
        chk("run.req_in_wait", {31'h0, imem_req}, 32'h0);
        tick(1);
        #1;
        chk("run.valid_2cyc", {31'h0, out_valid}, 32'h1);
        drain("run.drain");
        chk("run.gap01", pop_cyc[1] - pop_cyc[0], 2);
        chk("run.gap12", pop_cyc[2] - pop_cyc[1], 2);

        // Stall fills the queue and freezes PC.
        do_reset();
        expect_out(32'h0, 32'h4, 1'b0);
        expect_out(32'h4, 32'h8, 1'b0);
        expect_out(32'h8, 32'hC, 1'b0);
        expect_out(32'hC, 32'h10, 1'b0);
        expect_out(32'h10, 32'h14, 1'b0);
        tick(4);
        stall = 1'b1;
        tick(4);
        #1;
        chk("stall.imem_req", {31'h0, imem_req}, 32'h0);
        chk("stall.pc_frozen", imem_addr, 32'hC);
        chk("stall.out_valid", {31'h0, out_valid}, 32'h1);
        tick(2);
        stall = 1'b0;
        drain("stall.drain");
        chk("stall.b2b_pop", pop_cyc[2] - pop_cyc[1], 1);

        // Redirect while waiting on a slow fetch.
        lat = 3;
        do_reset();
        expect_out(32'h40, 32'h44, 1'b0);
        expect_out(32'h44, 32'h48, 1'b0);
        tick(1);
        branch_sel = 1'b1;
        branch_pc  = 32'h43;
        tick(1);
        branch_sel = 1'b0;
        #1;
        chk("br.discard_noreq", {31'h0, imem_req}, 32'h0);
        tick(2);
        #1;
        chk("br.target_req", {31'h0, imem_req}, 32'h1);
        chk("br.target_addr", imem_addr, 32'h40);
        drain("br.drain");

        // Interrupt with a full, stalled queue; held level, no retrigger.
        lat = 1;
        do_reset();
        expect_out(32'h0, 32'h4, 1'b0);
        expect_out(32'h4, 32'h8, 1'b0);
        expect_out(32'h8, 32'hC, 1'b0);
        expect_out(32'hC, 32'h10, 1'b0);
        expect_out(32'h100, 32'h104, 1'b1);
        expect_out(32'h104, 32'h108, 1'b0);
        expect_out(32'h108, 32'h10C, 1'b0);
        expect_out(32'h10C, 32'h110, 1'b0);
        tick(10);
        stall = 1'b1;
        tick(3);
        intr_req = 1'b1;
        tick(2);
        #1;
        chk("intr.flushed", {31'h0, out_valid}, 32'h0);
        chk("intr.epc", epc, 32'h10);
        tick(2);
        stall = 1'b0;
        drain("intr.drain");
        intr_req = 1'b0;

        // Redirect overlapping a pending interrupt.
        do_reset();
        expect_out(32'h100, 32'h104, 1'b1);
        expect_out(32'h104, 32'h108, 1'b0);
        tick(1);
        intr_req = 1'b1;
        tick(1);
        branch_sel = 1'b1;
        branch_pc  = 32'h80;
        tick(1);
        branch_sel = 1'b0;
        intr_req   = 1'b0;
        tick(1);
        #1;
        chk("brintr.epc", epc, 32'h80);
        drain("brintr.drain");

        // PC wrap, then reset in the middle of a fetch.
        do_reset();
        expect_out(32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0);
        expect_out(32'hFFFF_FFFC, 32'h0, 1'b0);
        expect_out(32'h0, 32'h4, 1'b0);
        branch_sel = 1'b1;
        branch_pc  = 32'hFFFF_FFF8;
        tick(1);
        branch_sel = 1'b0;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        #1;
        chk("wrap.drained", exp_q.size(), 0);
        chk("wrap.rst_valid", {31'h0, out_valid}, 32'h0);
        chk("wrap.rst_addr", imem_addr, 32'h0);
        expect_out(32'h0, 32'h4, 1'b0);
        expect_out(32'h4, 32'h8, 1'b0);
        drain("wrap.restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
